// File: rtl/qam16_pkg.sv
// Shared constants and types for the 16-QAM receive demapper.
package qam16_pkg;

    localparam logic [1:0] GRAY_M3 = 2'b00;
    localparam logic [1:0] GRAY_M1 = 2'b01;
    localparam logic [1:0] GRAY_P1 = 2'b11;
    localparam logic [1:0] GRAY_P3 = 2'b10;

    localparam int LEVEL_A_DEFAULT = 4096;

    typedef logic [3:0] sym_t;

endpackage

// File: rtl/qam16_axis_slicer.sv
// Four-level decision on one signed axis, returned as a 2-bit Gray code.
module qam16_axis_slicer
    import qam16_pkg::*;
#(
    parameter int DW      = 16,
    parameter int LEVEL_A = LEVEL_A_DEFAULT
) (
    input  logic signed [DW-1:0] i_x,
    output logic        [1:0]    o_gray
);

    // Two guard bits keep +/-2A representable even when 2A sits at the edge of DW.
    localparam logic signed [DW+1:0] TH_POS = (DW+2)'(2 * LEVEL_A);
    localparam logic signed [DW+1:0] TH_NEG = -TH_POS;

    logic signed [DW+1:0] w_x;

    assign w_x = {{2{i_x[DW-1]}}, i_x};

    always_comb begin
        o_gray = GRAY_M3;
        if (w_x >= TH_POS) begin
            o_gray = GRAY_P3;
        end else if (!w_x[DW+1]) begin
            o_gray = GRAY_P1;
        end else if (w_x >= TH_NEG) begin
            o_gray = GRAY_M1;
        end
    end

endmodule

// File: rtl/qam16_demapper.sv
// 16-QAM demapper: decimate I/Q samples, slice both axes, pack symbol pairs
// into bytes and present them through a one-entry valid/ready buffer.
module qam16_demapper
    import qam16_pkg::*;
#(
    parameter int DW      = 16,
    parameter int SPS     = 4,
    parameter int LEVEL_A = LEVEL_A_DEFAULT,
    localparam int PW     = $clog2(SPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [DW-1:0] din_q,
    input  logic                 din_valid,
    input  logic [PW-1:0]        phase,
    output logic [3:0]           sym_out,
    output logic                 sym_valid,
    output logic [7:0]           byte_out,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 overflow
);

    logic [PW-1:0] r_cnt;
    sym_t          r_sym;
    logic          r_sym_valid;
    logic          r_nibble_sel;
    sym_t          r_held;
    logic          r_load;
    logic [7:0]    r_pack;
    logic [7:0]    r_byte;
    logic          r_byte_valid;
    logic          r_overflow;

    logic [1:0]    w_gray_i;
    logic [1:0]    w_gray_q;
    logic          w_pick;

    qam16_axis_slicer #(.DW(DW), .LEVEL_A(LEVEL_A)) u_slice_i (
        .i_x    (din_i),
        .o_gray (w_gray_i)
    );

    qam16_axis_slicer #(.DW(DW), .LEVEL_A(LEVEL_A)) u_slice_q (
        .i_x    (din_q),
        .o_gray (w_gray_q)
    );

    // A phase value of SPS or above can never equal the counter, so nothing is picked.
    assign w_pick = din_valid && (r_cnt == phase);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_sym        <= '0;
            r_sym_valid  <= 1'b0;
            r_nibble_sel <= 1'b0;
            r_held       <= '0;
            r_load       <= 1'b0;
            r_pack       <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (din_valid) begin
                r_cnt <= (r_cnt == PW'(SPS - 1)) ? '0 : r_cnt + 1'b1;
            end

            r_sym_valid <= w_pick;
            if (w_pick) begin
                r_sym <= {w_gray_i, w_gray_q};
            end

            r_load <= 1'b0;
            if (r_sym_valid) begin
                if (!r_nibble_sel) begin
                    r_held       <= r_sym;
                    r_nibble_sel <= 1'b1;
                end else begin
                    r_pack       <= {r_held, r_sym};
                    r_load       <= 1'b1;
                    r_nibble_sel <= 1'b0;
                end
            end

            // A new byte may displace the held one only when it is being accepted.
            if (r_load) begin
                if (!r_byte_valid || byte_ready) begin
                    r_byte       <= r_pack;
                    r_byte_valid <= 1'b1;
                end else begin
                    r_overflow   <= 1'b1;
                end
            end else if (r_byte_valid && byte_ready) begin
                r_byte_valid <= 1'b0;
            end
        end
    end

    assign sym_out    = r_sym;
    assign sym_valid  = r_sym_valid;
    assign byte_out   = r_byte;
    assign byte_valid = r_byte_valid;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_qam16_demapper.sv
// Bench for qam16_demapper: per-cycle comparison against a behavioural model
// plus directed vectors with hand-computed symbols and bytes.
module tb_qam16_demapper;

    localparam int SPS = 4;
    localparam int A   = 4096;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] din_i = '0;
    logic signed [15:0] din_q = '0;
    logic               din_valid = 1'b0;
    logic [1:0]         phase = '0;
    logic               byte_ready = 1'b1;
    logic [3:0]         sym_out;
    logic               sym_valid;
    logic [7:0]         byte_out;
    logic               byte_valid;
    logic               overflow;

    logic [3:0]         sym_out5;
    logic               sym_valid5;
    logic [7:0]         byte_out5;
    logic               byte_valid5;
    logic               overflow5;

    qam16_demapper #(.DW(16), .SPS(SPS), .LEVEL_A(A)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .din_i      (din_i),
        .din_q      (din_q),
        .din_valid  (din_valid),
        .phase      (phase),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .overflow   (overflow)
    );

    // Five samples per symbol gives a 3-bit phase port, so phase=5 is reachable.
    qam16_demapper #(.DW(16), .SPS(5), .LEVEL_A(A)) u_dut5 (
        .clk        (clk),
        .reset      (reset),
        .din_i      (din_i),
        .din_q      (din_q),
        .din_valid  (din_valid),
        .phase      (3'd5),
        .sym_out    (sym_out5),
        .sym_valid  (sym_valid5),
        .byte_out   (byte_out5),
        .byte_valid (byte_valid5),
        .byte_ready (1'b1),
        .overflow   (overflow5)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    int         m_cnt   = 0;
    bit         m_symv  = 0;
    logic [3:0] m_sym   = '0;
    bit         m_half  = 0;
    logic [3:0] m_held  = '0;
    bit         m_loadv = 0;
    logic [7:0] m_load  = '0;
    logic [7:0] m_byte  = '0;
    bit         m_bv    = 0;
    bit         m_ovf   = 0;

    function automatic logic [1:0] slice(input int x);
        int lvl;
        if (x >= 2 * A)       lvl = 3;
        else if (x >= 0)      lvl = 1;
        else if (x >= -2 * A) lvl = -1;
        else                  lvl = -3;
        case (lvl)
            3:       return 2'b10;
            1:       return 2'b11;
            -1:      return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_symv = 0; m_sym = '0; m_half = 0; m_held = '0;
            m_loadv = 0; m_load = '0; m_byte = '0; m_bv = 0; m_ovf = 0;
        end else begin
            if (m_loadv) begin
                if (!m_bv || byte_ready) begin
                    m_byte = m_load;
                    m_bv   = 1;
                end else begin
                    m_ovf  = 1;
                end
            end else if (m_bv && byte_ready) begin
                m_bv = 0;
            end
            m_loadv = 0;
            if (m_symv) begin
                if (!m_half) begin
                    m_held = m_sym;
                    m_half = 1;
                end else begin
                    m_load  = {m_held, m_sym};
                    m_loadv = 1;
                    m_half  = 0;
                end
            end
            m_symv = 0;
            if (din_valid) begin
                if (m_cnt == int'(phase)) begin
                    m_sym  = {slice(din_i), slice(din_q)};
                    m_symv = 1;
                end
                m_cnt = (m_cnt + 1) % SPS;
            end
        end
    end

    // ---------------- literal expectations queued by the stimulus ----------------
    string       lit_name [0:127];
    logic [31:0] lit_act  [0:127];
    logic [31:0] lit_exp  [0:127];
    int          lit_wr = 0;
    int          lit_rd = 0;

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_name[lit_wr] = name;
        lit_act[lit_wr]  = act;
        lit_exp[lit_wr]  = exp;
        lit_wr++;
    endtask

    logic [3:0] sym_log[$];
    logic [7:0] byte_log[$];
    int         n_sym5 = 0;

    function automatic logic [31:0] sym_at(input int k);
        if (k < sym_log.size()) return 32'(sym_log[k]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] byte_at(input int k);
        if (k < byte_log.size()) return 32'(byte_log[k]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- single compare process ----------------
    always @(negedge clk) begin
        chk("sym_valid",  32'(sym_valid),  32'(m_symv));
        chk("sym_out",    32'(sym_out),    32'(m_sym));
        chk("byte_valid", 32'(byte_valid), 32'(m_bv));
        chk("byte_out",   32'(byte_out),   32'(m_byte));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("phase5_sym_valid", 32'(sym_valid5), 32'd0);
        if (sym_valid) sym_log.push_back(sym_out);
        if (sym_valid5) n_sym5++;
        if (byte_valid && byte_ready) begin
            byte_log.push_back(byte_out);
            $display("byte accepted 0x%02h", byte_out);
        end
        while (lit_rd < lit_wr) begin
            chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic sample(input int i, input int q);
        @(posedge clk); #2;
        din_i = 16'(i); din_q = 16'(q); din_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            din_i = '0; din_q = '0; din_valid = 1'b0;
        end
    endtask

    // One symbol period with phase 0: the first sample is the one decided.
    task automatic send_sym(input int i, input int q);
        sample(i, q); sample(0, 0); sample(0, 0); sample(0, 0);
    endtask

    int s0, b0;

    initial begin
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;

        // reset then idle
        idle(20);
        lit("idle_sym_count", 32'(sym_log.size()), 32'd0);
        lit("idle_sym_out", 32'(sym_out), 32'h0);
        lit("idle_byte_out", 32'(byte_out), 32'h0);
        lit("idle_byte_valid", 32'(byte_valid), 32'h0);
        lit("idle_overflow", 32'(overflow), 32'h0);

        // basic decode
        s0 = sym_log.size(); b0 = byte_log.size();
        send_sym(12288, -12288);
        send_sym(-4096, 4096);
        idle(6);
        lit("decode_sym_count", 32'(sym_log.size() - s0), 32'd2);
        lit("decode_sym0", sym_at(s0), 32'h8);
        lit("decode_sym1", sym_at(s0 + 1), 32'h7);
        lit("decode_byte_count", 32'(byte_log.size() - b0), 32'd1);
        lit("decode_byte", byte_at(b0), 32'h87);
        lit("decode_byte_valid_low", 32'(byte_valid), 32'h0);

        // threshold ties and DW extremes
        s0 = sym_log.size(); b0 = byte_log.size();
        send_sym(8192, 0);
        send_sym(-8192, -1);
        send_sym(-8193, 8191);
        send_sym(32767, -32768);
        idle(6);
        lit("tie_sym0", sym_at(s0), 32'hB);
        lit("tie_sym1", sym_at(s0 + 1), 32'h5);
        lit("tie_sym2", sym_at(s0 + 2), 32'h3);
        lit("extreme_sym3", sym_at(s0 + 3), 32'h8);
        lit("tie_byte0", byte_at(b0), 32'hB5);
        lit("tie_byte1", byte_at(b0 + 1), 32'h38);

        // phase select
        s0 = sym_log.size(); b0 = byte_log.size();
        phase = 2'd2;
        sample(-12288, -12288); sample(-12288, -12288); sample(12288, 12288); sample(-12288, -12288);
        sample(-12288, -12288); sample(-12288, -12288); sample(-12288, 4096); sample(-12288, -12288);
        idle(6);
        phase = 2'd0;
        lit("phase2_sym_count", 32'(sym_log.size() - s0), 32'd2);
        lit("phase2_sym0", sym_at(s0), 32'hA);
        lit("phase2_sym1", sym_at(s0 + 1), 32'h3);
        lit("phase2_byte", byte_at(b0), 32'hA3);

        // backpressure with a dropped byte
        b0 = byte_log.size();
        byte_ready = 1'b0;
        send_sym(12288, -12288);
        send_sym(-4096, 4096);
        send_sym(-12288, 12288);
        send_sym(-12288, -4096);
        idle(6);
        lit("bp_byte_out_held", 32'(byte_out), 32'h87);
        lit("bp_byte_valid", 32'(byte_valid), 32'h1);
        lit("bp_overflow", 32'(overflow), 32'h1);
        byte_ready = 1'b1;
        idle(3);
        lit("bp_accept_count", 32'(byte_log.size() - b0), 32'd1);
        lit("bp_accept_byte", byte_at(b0), 32'h87);
        lit("bp_byte_valid_low", 32'(byte_valid), 32'h0);
        lit("bp_overflow_sticky", 32'(overflow), 32'h1);

        // mid-byte reset discards the held high nibble
        s0 = sym_log.size(); b0 = byte_log.size();
        send_sym(12288, -12288);
        idle(2);
        @(posedge clk); #2; reset = 1'b1;
        @(posedge clk); #2; reset = 1'b0;
        send_sym(-12288, 4096);
        send_sym(4096, -12288);
        idle(6);
        lit("rst_sym0", sym_at(s0), 32'h8);
        lit("rst_byte_count", 32'(byte_log.size() - b0), 32'd1);
        lit("rst_byte", byte_at(b0), 32'h3C);
        lit("rst_overflow", 32'(overflow), 32'h0);

        // a byte completing while the held one is accepted replaces it cleanly
        b0 = byte_log.size();
        byte_ready = 1'b0;
        send_sym(12288, -12288);
        send_sym(-4096, 4096);
        send_sym(-12288, 12288);
        sample(-12288, -4096);
        sample(0, 0);
        sample(0, 0);
        byte_ready = 1'b1;
        sample(0, 0);
        idle(6);
        lit("swap_byte_count", 32'(byte_log.size() - b0), 32'd2);
        lit("swap_byte0", byte_at(b0), 32'h87);
        lit("swap_byte1", byte_at(b0 + 1), 32'h21);
        lit("swap_overflow", 32'(overflow), 32'h0);
        lit("swap_byte_valid_low", 32'(byte_valid), 32'h0);

        lit("phase5_sym_count", 32'(n_sym5), 32'd0);
        lit("phase5_byte_valid", 32'(byte_valid5), 32'h0);

        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qam16_demapper.md
Name: qam16_demapper

Overview:
- Receive-side counterpart of the 16-QAM modulator/FIR transmit chain.
- Accepts oversampled I/Q baseband samples and decimates to one sample per symbol at a programmable phase.
- Slices each axis to a 4-level decision, Gray-decodes it to a 4-bit symbol, and packs symbol pairs into bytes.
- Output bytes go through a single-entry valid/ready buffer, with a sticky overflow flag for dropped bytes.

Parameters:
- DW, 16, signed sample width of each of din_i and din_q.
- SPS, 4, samples per symbol; must be ≥2. Phase/counter width PW = $clog2(SPS).
- LEVEL_A, 4096, unit amplitude: nominal constellation levels are ±A and ±3A; decision thresholds are 0 and ±2A.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- din_i  in  DW  in-phase sample, signed two's complement.
- din_q  in  DW  quadrature sample, signed two's complement.
- din_valid  in  1  qualifies din_i/din_q for one cycle.
- phase  in  PW  decimation phase (0..SPS-1); the sample taken is the one with cnt==phase.
- sym_out  out  4  decided symbol: [3:2] = I bits, [1:0] = Q bits.
- sym_valid  out  1  one-cycle strobe qualifying sym_out.
- byte_out  out  8  packed byte: first symbol in [7:4], second in [3:0].
- byte_valid  out  1  byte held until it is accepted.
- byte_ready  in  1  downstream accept.
- overflow  out  1  sticky; set when a completed byte is dropped.

Behaviour:
- Reset values: sym_out=0, sym_valid=0, byte_out=0, byte_valid=0, overflow=0. Internal sample counter cnt=0, nibble_sel=0, held nibble=0.
- Sample counter:
  - Increments on every din_valid and wraps SPS-1 → 0.
  - Holds when din_valid=0.
- Decimation:
  - A sample is "picked" when din_valid=1 and cnt==phase (compare uses the pre-increment cnt).
  - Changing phase takes effect on the next valid sample.
  - phase ≥ SPS never matches, so no symbols are produced.
- Slicer, per axis, signed compare, evaluated in order:
  - x ≥ 2A → +3, code 10
  - x ≥ 0 → +1, code 11
  - x ≥ −2A → −1, code 01
  - otherwise → −3, code 00
  - Exact ties therefore go to the upper region.
  - Values at or beyond the DW extremes decide normally; no saturation logic.
- Latency:
  - Sample picked in cycle n → sym_out registered and sym_valid=1 in cycle n+1, for exactly one cycle.
  - Back-to-back symbols are possible only if SPS=1, which is disallowed, so sym_valid is never high on consecutive cycles.
- Packer:
  - On sym_valid with nibble_sel=0: store sym_out as the high nibble, set nibble_sel=1.
  - On sym_valid with nibble_sel=1: form {held, sym_out}, raise load in cycle n+2, clear nibble_sel.
- Output buffer (one entry):
  - load with byte_valid=0 → byte_out=new, byte_valid=1.
  - load with byte_valid=1 and byte_ready=1 → new byte replaces the old one; byte_valid stays 1; nothing is lost.
  - load with byte_valid=1 and byte_ready=0 → new byte dropped, byte_out unchanged, overflow←1.
  - No load with byte_valid=1 and byte_ready=1 → byte_valid←0; byte_out keeps its last value.
  - byte_out is stable while byte_valid=1 and byte_ready=0.
- overflow clears only on reset.
- Reset mid-operation:
  - Clears cnt, nibble_sel and any half-packed nibble, plus all outputs.
  - The first symbol after reset is a high nibble.

Decomposition:
- Package qam16_pkg holds:
  - 2-bit Gray code constants: GRAY_M3=2'b00, GRAY_M1=2'b01, GRAY_P1=2'b11, GRAY_P3=2'b10.
  - The default LEVEL_A.
  - A symbol typedef of 4 bits.
- Sub-module qam16_axis_slicer: combinational, parameters DW and LEVEL_A, signed DW-bit input to 2-bit Gray output. Instantiated twice (I and Q).
- Counter, packer and output buffer stay in the top module.

Test Plan:
- Reset then idle: hold reset 2 cycles, then 20 cycles with din_valid=0 → all outputs 0, sym_valid never asserted.
- Decode, SPS=4, phase=0, byte_ready=1:
  - Send 8 valid samples. Sample 0 is I=+12288, Q=−12288; sample 4 is I=−4096, Q=+4096; all others are 0.
  - Expect sym_out=0x8 one cycle after sample 0 and sym_out=0x7 one cycle after sample 4.
  - Expect byte_out=0x87 with byte_valid for 1 cycle.
- Threshold ties: I=8192, Q=0 → 0xB. I=−8192, Q=−1 → 0x5. I=−8193, Q=8191 → 0x3.
- Phase select, phase=2: sample 2 is I=+12288, Q=+12288; others are −12288 → sym_out=0xA (samples 0/1/3 ignored). Set phase=5 → no sym_valid over 16 samples.
- Backpressure, byte_ready=0:
  - Deliver 2 complete bytes (0x87, then 0x21) → byte_out stays 0x87 and overflow=1.
  - Raise byte_ready → 0x87 accepted, byte_valid falls, overflow stays 1.
  - A byte completing in the same cycle as an acceptance replaces the old one with no overflow.
- Mid-byte reset: one symbol 0x8, then a 1-cycle reset, then symbols 0x3, 0xC → byte_out=0x3C (the 0x8 is discarded) and overflow=0.
